// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared raster constants for the video path.
//   - 640x480@60 active sizes, porches, sync widths and sync polarity
//   - derived blanking and total counts
//   - coordinate type and a small window helper used by the timing axes
// Other video blocks take their geometry from here rather than repeating literals.
package vga_timing_pkg;

    localparam int unsigned COORD_W   = 11;
    localparam int unsigned MAX_TOTAL = 2048;

    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FP     = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BP     = 48;
    localparam int unsigned VGA_H_BLANK  = VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int unsigned VGA_H_TOTAL  = VGA_H_BLANK + VGA_H_ACTIVE;

    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FP     = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BP     = 33;
    localparam int unsigned VGA_V_BLANK  = VGA_V_FP + VGA_V_SYNC + VGA_V_BP;
    localparam int unsigned VGA_V_TOTAL  = VGA_V_BLANK + VGA_V_ACTIVE;

    // Level driven on hsync/vsync while inside the sync pulse.
    localparam logic VGA_HSYNC_ACTIVE = 1'b0;
    localparam logic VGA_VSYNC_ACTIVE = 1'b0;

    typedef logic [COORD_W-1:0] coord_t;

    // True when lo <= c < hi.
    function automatic logic inWindow(input coord_t c, input coord_t lo, input coord_t hi);
        return (c >= lo) && (c < hi);
    endfunction

endpackage

// File: rtl/vga_timing_if.sv
// vga_timing_if: raster timing bundle from the timing generator to display stages.
//   pixelEnable  visible-pixel strobe, one clk per tick
//   pixelX/Y     signed (two's-complement) position, negative during blanking
//   lineStart    one-clk pulse on the tick that begins a line
//   frameStart   one-clk pulse on the tick that begins a frame
//   hsync/vsync  monitor sync, active-low
//   vblank       level, high during vertical blanking
interface vga_timing_if;
    import vga_timing_pkg::*;

    logic   pixelEnable;
    coord_t pixelX;
    coord_t pixelY;
    logic   lineStart;
    logic   frameStart;
    logic   hsync;
    logic   vsync;
    logic   vblank;

    modport master (
        output pixelEnable, pixelX, pixelY, lineStart, frameStart, hsync, vsync, vblank
    );

    modport slave (
        input pixelEnable, pixelX, pixelY, lineStart, frameStart, hsync, vsync, vblank
    );

endinterface

// File: rtl/vga_timing_axis.sv
// vga_timing_axis: one raster axis (horizontal or vertical).
//   clk, rst_n   clock, asynchronous active-low reset
//   advance      step the counter by one position this cycle
//   counter      position in 0..TOTAL-1, blanking first then active area
//   position     counter - BLANK (mod 2^11): negative while blanking
//   wrap         counter is stepping from TOTAL-1 back to 0 this cycle
//   sync_n       low while counter is inside [FP, FP+SYNC)
//   blank        high while counter is in the blanking interval
//   activeNext   the value the counter takes at this edge is in the active area
// Reset parks the axis on its last position so the first advance lands on 0.
module vga_timing_axis
    import vga_timing_pkg::*;
#(
    parameter int unsigned ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned FP     = VGA_H_FP,
    parameter int unsigned SYNC   = VGA_H_SYNC,
    parameter int unsigned BP     = VGA_H_BP
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   advance,
    output coord_t counter,
    output coord_t position,
    output logic   wrap,
    output logic   sync_n,
    output logic   blank,
    output logic   activeNext
);

    localparam int unsigned BLANK = FP + SYNC + BP;
    localparam int unsigned TOTAL = BLANK + ACTIVE;

    localparam coord_t LAST       = coord_t'(TOTAL - 1);
    localparam coord_t BLANK_C    = coord_t'(BLANK);
    localparam coord_t SYNC_LO    = coord_t'(FP);
    localparam coord_t SYNC_HI    = coord_t'(FP + SYNC);

    coord_t counterNext;

    always_comb begin
        wrap        = advance && (counter == LAST);
        counterNext = counter;
        if (advance) begin
            counterNext = (counter == LAST) ? '0 : counter + coord_t'(1);
        end
        activeNext  = (counterNext >= BLANK_C);
    end

    // Every registered output is derived from the same next count, so they
    // all move together with no relative skew.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter  <= LAST;
            position <= LAST - BLANK_C;
            sync_n   <= !inWindow(LAST, SYNC_LO, SYNC_HI);
            blank    <= (LAST < BLANK_C);
        end else if (advance) begin
            counter  <= counterNext;
            position <= counterNext - BLANK_C;
            sync_n   <= !inWindow(counterNext, SYNC_LO, SYNC_HI);
            blank    <= (counterNext < BLANK_C);
        end
    end

endmodule

// File: rtl/vga_timing.sv
// vga_timing: raster timing generator for the CHIP-8 video path.
//   clk     pixel (or faster system) clock
//   rst_n   asynchronous active-low reset
//   vid     vga_timing_if master: pixel strobe, coordinates, line/frame pulses, syncs
// CLK_DIV clk cycles make one pixel tick. Counters and level outputs change only
// on tick edges; pixelEnable, lineStart and frameStart are one-clk pulses per tick.
module vga_timing
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FP     = VGA_H_FP,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BP     = VGA_H_BP,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FP     = VGA_V_FP,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BP     = VGA_V_BP,
    parameter int unsigned CLK_DIV  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    vga_timing_if.master vid
);

    localparam int unsigned H_TOTAL = H_FP + H_SYNC + H_BP + H_ACTIVE;
    localparam int unsigned V_TOTAL = V_FP + V_SYNC + V_BP + V_ACTIVE;

    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : gTotalCheck
        $error("vga_timing: H_TOTAL/V_TOTAL exceed 11-bit coordinate range");
    end
    if (CLK_DIV < 1) begin : gDivCheck
        $error("vga_timing: CLK_DIV must be at least 1");
    end

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] divQ;
    logic             tick;

    // Divider resets to its last value so the first edge after reset is a tick.
    assign tick = (divQ == DIV_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            divQ <= DIV_LAST;
        end else begin
            divQ <= tick ? '0 : divQ + DIV_W'(1);
        end
    end

    coord_t hCount, vCount, hPos, vPos;
    logic   hWrap, vWrap, hSyncN, vSyncN, hBlank, vBlank, hActiveNext, vActiveNext;

    vga_timing_axis #(
        .ACTIVE(H_ACTIVE),
        .FP    (H_FP),
        .SYNC  (H_SYNC),
        .BP    (H_BP)
    ) hAxis (
        .clk       (clk),
        .rst_n     (rst_n),
        .advance   (tick),
        .counter   (hCount),
        .position  (hPos),
        .wrap      (hWrap),
        .sync_n    (hSyncN),
        .blank     (hBlank),
        .activeNext(hActiveNext)
    );

    // hWrap already includes tick, so the vertical axis steps once per line.
    vga_timing_axis #(
        .ACTIVE(V_ACTIVE),
        .FP    (V_FP),
        .SYNC  (V_SYNC),
        .BP    (V_BP)
    ) vAxis (
        .clk       (clk),
        .rst_n     (rst_n),
        .advance   (hWrap),
        .counter   (vCount),
        .position  (vPos),
        .wrap      (vWrap),
        .sync_n    (vSyncN),
        .blank     (vBlank),
        .activeNext(vActiveNext)
    );

    logic pixelEnableQ, lineStartQ, frameStartQ;

    // Pulses are rewritten every clk so they last exactly one cycle per tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixelEnableQ <= 1'b0;
            lineStartQ   <= 1'b0;
            frameStartQ  <= 1'b0;
        end else begin
            pixelEnableQ <= tick && hActiveNext && vActiveNext;
            lineStartQ   <= hWrap;
            frameStartQ  <= hWrap && vWrap;
        end
    end

    assign vid.pixelEnable = pixelEnableQ;
    assign vid.pixelX      = hPos;
    assign vid.pixelY      = vPos;
    assign vid.lineStart   = lineStartQ;
    assign vid.frameStart  = frameStartQ;
    assign vid.hsync       = hSyncN;
    assign vid.vsync       = vSyncN;
    assign vid.vblank      = vBlank;

    logic unusedAxis;
    assign unusedAxis = ^{hCount, vCount, hBlank};

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: three instances (default 640x480 at CLK_DIV=1 and a small
// raster at CLK_DIV=2 and 3) checked every cycle against a closed-form model of the
// raster position derived from the number of clk edges since reset release.
module tb_vga_timing;
    import vga_timing_pkg::*;

    localparam int S_HA = 20, S_HFP = 3, S_HS = 4, S_HBP = 5;
    localparam int S_VA = 6,  S_VFP = 2, S_VS = 2, S_VBP = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vga_timing_if busA ();
    vga_timing_if busB ();
    vga_timing_if busC ();

    vga_timing dutA (
        .clk  (clk),
        .rst_n(rst_n),
        .vid  (busA)
    );

    vga_timing #(
        .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
        .CLK_DIV (2)
    ) dutB (
        .clk  (clk),
        .rst_n(rst_n),
        .vid  (busB)
    );

    vga_timing #(
        .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
        .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
        .CLK_DIV (3)
    ) dutC (
        .clk  (clk),
        .rst_n(rst_n),
        .vid  (busC)
    );

    typedef struct packed {
        logic        pe;
        logic [10:0] px;
        logic [10:0] py;
        logic        ls;
        logic        fs;
        logic        hs;
        logic        vs;
        logic        vb;
    } vid_t;

    vid_t obsA, obsB, obsC;
    assign obsA = {busA.pixelEnable, busA.pixelX, busA.pixelY, busA.lineStart,
                   busA.frameStart, busA.hsync, busA.vsync, busA.vblank};
    assign obsB = {busB.pixelEnable, busB.pixelX, busB.pixelY, busB.lineStart,
                   busB.frameStart, busB.hsync, busB.vsync, busB.vblank};
    assign obsC = {busC.pixelEnable, busC.pixelX, busC.pixelY, busC.lineStart,
                   busC.frameStart, busC.hsync, busC.vsync, busC.vblank};

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Recorded during the first run after reset for the per-line/per-frame checks.
    int lsA[$];
    int preA[$];
    int zeroA[$];
    int fsB[$];
    int hsLowA = 0;
    logic [10:0] hsFirstPxA = '0;
    logic hsSeenA = 1'b0;

    // Expected outputs c clk edges after reset release (c=0: still in reset).
    function automatic vid_t model(input int ha, input int hfp, input int hsy, input int hbp,
                                   input int va, input int vfp, input int vsy, input int vbp,
                                   input int div, input int c);
        vid_t e;
        int hb, vbl, ht, vt, k, n, h, v;
        bit tk;
        hb  = hfp + hsy + hbp;
        vbl = vfp + vsy + vbp;
        ht  = hb + ha;
        vt  = vbl + va;
        if (c == 0) begin
            e.pe = 1'b0; e.px = 11'(ha - 1); e.py = 11'(va - 1);
            e.ls = 1'b0; e.fs = 1'b0; e.hs = 1'b1; e.vs = 1'b1; e.vb = 1'b0;
            return e;
        end
        k  = (c - 1) / div;
        tk = ((c - 1) % div) == 0;
        n  = k % (ht * vt);
        h  = n % ht;
        v  = n / ht;
        e.px = 11'(h - hb);
        e.py = 11'(v - vbl);
        e.pe = tk && (h >= hb) && (v >= vbl);
        e.ls = tk && (h == 0);
        e.fs = tk && (n == 0);
        e.hs = !((h >= hfp) && (h < hfp + hsy));
        e.vs = !((v >= vfp) && (v < vfp + vsy));
        e.vb = (v < vbl);
        return e;
    endfunction

    task automatic chk(input string dut, input string field, input int c,
                       input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s cyc=%0d observed=%0h expected=%0h", dut, field, c, obs, exp);
        end
    endtask

    task automatic chk_vid(input string d, input int c, input vid_t o, input vid_t e);
        chk(d, "pixelEnable", c, 32'(o.pe), 32'(e.pe));
        chk(d, "pixelX",      c, 32'(o.px), 32'(e.px));
        chk(d, "pixelY",      c, 32'(o.py), 32'(e.py));
        chk(d, "lineStart",   c, 32'(o.ls), 32'(e.ls));
        chk(d, "frameStart",  c, 32'(o.fs), 32'(e.fs));
        chk(d, "hsync",       c, 32'(o.hs), 32'(e.hs));
        chk(d, "vsync",       c, 32'(o.vs), 32'(e.vs));
        chk(d, "vblank",      c, 32'(o.vb), 32'(e.vb));
    endtask

    task automatic check_all(input int c);
        chk_vid("A", c, obsA, model(640, 16, 96, 48, 480, 10, 2, 33, 1, c));
        chk_vid("B", c, obsB, model(S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP, 2, c));
        chk_vid("C", c, obsC, model(S_HA, S_HFP, S_HS, S_HBP, S_VA, S_VFP, S_VS, S_VBP, 3, c));
    endtask

    // Advance n clk edges, checking all instances half a cycle after each edge.
    task automatic run(input int n, input bit record);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            check_all(cyc);
            if (record) begin
                if (obsA.ls) lsA.push_back(cyc);
                if (obsA.px == 11'h7FC) preA.push_back(cyc);
                if (obsA.px == 11'h000) zeroA.push_back(cyc);
                if (obsB.fs) fsB.push_back(cyc);
                if (cyc <= 800 && !obsA.hs) begin
                    hsLowA++;
                    if (!hsSeenA) begin
                        hsSeenA = 1'b1;
                        hsFirstPxA = obsA.px;
                    end
                end
            end
        end
    endtask

    // Assert reset asynchronously, check reset values before any edge, release.
    task automatic async_reset(input int offset);
        #(offset);
        rst_n = 1'b0;
        #1;
        check_all(0);
        @(negedge clk);
        check_all(0);
        rst_n = 1'b1;
        cyc = 0;
    endtask

    initial begin
        int wait_n;
        bit found;

        // Reset held over several edges, then released between edges.
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all(0);
        rst_n = 1'b1;
        cyc = 0;

        run(2000, 1'b1);

        chk("A", "lineStartCount", 0, 32'(lsA.size()), 32'd3);
        if (lsA.size() >= 3) begin
            chk("A", "linePeriod0", 0, 32'(lsA[1] - lsA[0]), 32'd800);
            chk("A", "linePeriod1", 0, 32'(lsA[2] - lsA[1]), 32'd800);
        end
        chk("A", "prefetchCount", 0, 32'(preA.size()), 32'd3);
        chk("A", "zeroCount", 0, 32'(zeroA.size()), 32'd3);
        if (preA.size() == 3 && zeroA.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                chk("A", "prefetchLead", i, 32'(zeroA[i] - preA[i]), 32'd4);
            end
        end
        chk("A", "hsyncLowTicks", 0, 32'(hsLowA), 32'd96);
        chk("A", "hsyncFirstPx", 0, 32'(hsFirstPxA), 32'h770);
        chk("B", "frameCount", 0, 32'(fsB.size()), 32'd3);
        if (fsB.size() >= 2) begin
            chk("B", "framePeriod", 0, 32'(fsB[1] - fsB[0]), 32'(32 * 13 * 2));
        end

        // Reset mid-line at pixelX=300 on the default raster.
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            if (obsA.px == 11'd300) found = 1'b1;
            else run(1, 1'b0);
        end
        chk("A", "reachPx300", cyc, 32'(found), 32'd1);
        async_reset(1);
        run(1000, 1'b0);

        // Randomised run lengths and reset assertion points.
        for (int r = 0; r < 3; r++) begin
            wait_n = int'($urandom_range(100, 1500));
            run(wait_n, 1'b0);
            async_reset(int'($urandom_range(1, 3)));
            run(int'($urandom_range(50, 400)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
